// File: rtl/q2a03_phase_gen_if.sv
// Phase-generator bus: control inputs (clock enable, re-align) and all
// per-channel phase outputs grouped into one interface.
//   master : drives G_ce / G_align, observes phase outputs (core / bench side)
//   slave  : the phase generator itself
// Signals:
//   G_ce     global clock enable, low freezes every channel
//   G_align  synchronous re-phase of every channel
//   G_phi    per-channel phase clock (high = phi2)
//   G_rise   per-channel 1-clock strobe on phi 0->1
//   G_fall   per-channel 1-clock strobe on phi 1->0
//   G_odd    per-channel parity of the fall counter
//   G_cycle  packed fall counters, ch0 in [CNT_W-1:0]
interface q2a03_phase_gen_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic                    G_ce;
    logic                    G_align;
    logic [NUM_CH-1:0]       G_phi;
    logic [NUM_CH-1:0]       G_rise;
    logic [NUM_CH-1:0]       G_fall;
    logic [NUM_CH-1:0]       G_odd;
    logic [NUM_CH*CNT_W-1:0] G_cycle;

    modport master (
        output G_ce, G_align,
        input  G_phi, G_rise, G_fall, G_odd, G_cycle
    );

    modport slave (
        input  G_ce, G_align,
        output G_phi, G_rise, G_fall, G_odd, G_cycle
    );
endinterface

// File: rtl/q2a03_phase_gen.sv
// Multi-channel clock-phase generator. Each channel divides the master clock
// by DIV_k into a two-phase clock whose high phase starts at tick HIGH_AT_k,
// and emits registered rise/fall strobes plus a fall-edge cycle counter.
// Ports:
//   G_clock  master clock, all logic on posedge
//   G_reset  asynchronous active-low reset
//   bus      q2a03_phase_gen_if slave: G_ce, G_align in; G_phi, G_rise,
//            G_fall, G_odd, G_cycle out
// Parameter packing: channel k lives in bits [8k+7:8k] of DIV / HIGH_AT,
// so the defaults give ch0 = /4 (high at 2) and ch1 = /12 (high at 6).
module q2a03_phase_gen #(
    parameter int                  NUM_CH  = 2,
    parameter logic [NUM_CH*8-1:0] DIV     = {8'd12, 8'd4},
    parameter logic [NUM_CH*8-1:0] HIGH_AT = {8'd6, 8'd2},
    parameter int                  CNT_W   = 32
) (
    input  logic                G_clock,
    input  logic                G_reset,
    q2a03_phase_gen_if.slave    bus
);

    logic [NUM_CH-1:0]            phi_v, rise_v, fall_v, odd_v;
    logic [NUM_CH-1:0][CNT_W-1:0] cyc_v;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [7:0] DIV_K = DIV[k*8 +: 8];
        localparam logic [7:0] HI_K  = HIGH_AT[k*8 +: 8];

        if (DIV_K < 8'd2 || HI_K < 8'd1 || HI_K > DIV_K - 8'd1) begin : g_bad_param
            $error("q2a03_phase_gen: channel %0d has illegal DIV/HIGH_AT", k);
        end

        logic [7:0]       tick_q, tick_nx;
        logic             phi_q, phi_nx, rise_q, fall_q;
        logic [CNT_W-1:0] cycle_q;

        // Tick runs 0..DIV-1; phi is high for ticks HIGH_AT..DIV-1. Reset and
        // align park the tick at DIV-1 so the first enabled clock lands on 0.
        always_comb begin
            tick_nx = (tick_q == DIV_K - 8'd1) ? 8'd0 : tick_q + 8'd1;
            phi_nx  = (tick_nx >= HI_K);
        end

        always_ff @(posedge G_clock or negedge G_reset) begin
            if (!G_reset) begin
                tick_q  <= DIV_K - 8'd1;
                phi_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                cycle_q <= '0;
            end else if (bus.G_align) begin
                // Forced low without a fall strobe; the counter keeps its count.
                tick_q  <= DIV_K - 8'd1;
                phi_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else if (bus.G_ce) begin
                tick_q  <= tick_nx;
                phi_q   <= phi_nx;
                rise_q  <= phi_nx & ~phi_q;
                fall_q  <= ~phi_nx & phi_q;
                if (~phi_nx & phi_q)
                    cycle_q <= cycle_q + CNT_W'(1);
            end else begin
                // Frozen: strobes drop so a held edge is never reported twice.
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end
        end

        assign phi_v[k]  = phi_q;
        assign rise_v[k] = rise_q;
        assign fall_v[k] = fall_q;
        assign odd_v[k]  = cycle_q[0];
        assign cyc_v[k]  = cycle_q;
    end

    assign bus.G_phi   = phi_v;
    assign bus.G_rise  = rise_v;
    assign bus.G_fall  = fall_v;
    assign bus.G_odd   = odd_v;
    assign bus.G_cycle = cyc_v;

endmodule
